uart_tx_cfg: RTL and testbench

Parametrised UART transmitter with an input FIFO and runtime frame format.
- Frame format is selectable per frame: 5-8 data bits, none/even/odd parity, 1 or 2 stop bits.
- Serialises bytes LSB-first onto a registered TxD line, using an internal per-frame-aligned baud counter.
- Sits between the processor-side byte producer (valid/ready) and the board TX pin.
- Generation after the fixed 8N2 transmitter; adds buffering, format control and back-to-back framing.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_tx_cfg_if.sv | 19 +
 rtl/uart_sync_fifo.sv | 54 +++++
 rtl/uart_tx_cfg.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: parity modes,
// FSM state encoding and frame-length helpers.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // cfg_len 0..3 selects 5..8 data bits
  function automatic logic [3:0] len_to_bits(input logic [1:0] len);
    return {2'b00, len} + 4'd5;
  endfunction

  function automatic logic [7:0] len_to_mask(input logic [1:0] len);
    return 8'hFF >> (2'd3 - len);
  endfunction

  // Encoding 3 behaves like PAR_NONE
  function automatic logic parity_enabled(input logic [1:0] par);
    return (par == PAR_EVEN) || (par == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Producer-side byte handshake plus per-frame format controls.
interface uart_tx_cfg_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] cfg_len;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;

  modport master (
    output in_data, in_valid, cfg_len, cfg_parity, cfg_stop2,
    input  in_ready
  );

  modport slave (
    input  in_data, in_valid, cfg_len, cfg_parity, cfg_stop2,
    output in_ready
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO; a push while full is dropped even when a
// pop happens on the same edge.
module uart_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter with per-frame format (5-8 data bits,
// none/even/odd parity, 1 or 2 stop bits) and zero-gap back-to-back frames.
//
// state     | meaning
// ST_IDLE   | line high, waiting for a queued byte
// ST_START  | start bit (txd low)
// ST_DATA   | data bits, LSB first
// ST_PARITY | parity bit
// ST_STOP   | one or two stop bits (txd high)
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  uart_tx_cfg_if.slave                  in_if,
  output logic                          txd,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BW           = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic [7:0] fifo_rdata;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (in_if.in_valid),
    .wdata_i (in_if.in_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign in_if.in_ready = !fifo_full;

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [3:0]    nbits_q, nbits_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    par_mode_q, par_mode_d;
  logic          stop2_q, stop2_d;
  logic          par_bit_q, par_bit_d;
  logic          txd_q, txd_d;
  logic          done_q, done_d;
  logic          bit_end;
  logic          last_data;
  logic          load;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign last_data = ({1'b0, bit_idx_q} == (nbits_q - 4'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      nbits_q    <= '0;
      shift_q    <= '0;
      par_mode_q <= PAR_NONE;
      stop2_q    <= 1'b0;
      par_bit_q  <= 1'b0;
      txd_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      nbits_q    <= nbits_d;
      shift_q    <= shift_d;
      par_mode_q <= par_mode_d;
      stop2_q    <= stop2_d;
      par_bit_q  <= par_bit_d;
      txd_q      <= txd_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = bit_end ? '0 : baud_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    nbits_d    = nbits_q;
    shift_d    = shift_q;
    par_mode_d = par_mode_q;
    stop2_d    = stop2_q;
    par_bit_d  = par_bit_q;
    done_d     = 1'b0;
    load       = 1'b0;
    pop        = 1'b0;
    txd_d      = 1'b1;

    case (state_q)
      ST_IDLE: begin
        baud_d = baud_q;
        if (!fifo_empty) load = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (last_data) begin
            bit_idx_d = '0;
            state_d   = parity_enabled(par_mode_q) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d   = ST_STOP;
          bit_idx_d = '0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop2_q && (bit_idx_q == 3'd0)) begin
            bit_idx_d = 3'd1;
          end else begin
            done_d = 1'b1;
            if (!fifo_empty) load = 1'b1;
            else             state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Format is captured only here, so cfg changes mid-frame wait for the next pop
    if (load) begin
      pop        = 1'b1;
      state_d    = ST_START;
      baud_d     = '0;
      bit_idx_d  = '0;
      shift_d    = fifo_rdata;
      nbits_d    = len_to_bits(in_if.cfg_len);
      par_mode_d = in_if.cfg_parity;
      stop2_d    = in_if.cfg_stop2;
      par_bit_d  = (^(fifo_rdata & len_to_mask(in_if.cfg_len)))
                   ^ (in_if.cfg_parity == PAR_ODD);
    end

    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
      ST_PARITY: txd_d = par_bit_d;
      default:   txd_d = 1'b1;
    endcase
  end

  assign txd        = txd_q;
  assign frame_done = done_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg at 10 clocks per bit, comparing the
// line against frames built from the format rules.
module tb_uart_tx_cfg;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       txd;
  logic       busy;
  logic       frame_done;
  logic [2:0] fifo_count;

  int errors = 0;
  int checks = 0;

  uart_tx_cfg_if bus ();

  uart_tx_cfg #(
    .CLK_FREQ   (1000),
    .BAUD       (100),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_if      (bus),
    .txd        (txd),
    .busy       (busy),
    .frame_done (frame_done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic set_cfg(input logic [1:0] len, input logic [1:0] par, input logic s2);
    bus.cfg_len    = len;
    bus.cfg_parity = par;
    bus.cfg_stop2  = s2;
  endtask

  task automatic wait_fall(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (txd === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL start_timeout: txd=%b, required 0 within %0d cycles", txd, budget);
    end
  endtask

  // Called on the first sample of the start bit; returns on the sample after
  // the last stop bit has ended (where frame_done must be high).
  task automatic check_frame(input logic [7:0] data, input logic [1:0] len,
                             input logic [1:0] par, input logic s2, input string tag);
    logic exp_bits [12];
    int   nd, n, ones;
    bit   bad;
    logic a_txd, a_busy, a_done;
    nd   = int'(len) + 5;
    ones = 0;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < nd; i++) begin
      exp_bits[1+i] = data[i];
      ones += int'(data[i]);
    end
    n = 1 + nd;
    if (par == 2'd1) begin
      exp_bits[n] = ((ones % 2) == 1);
      n++;
    end else if (par == 2'd2) begin
      exp_bits[n] = ((ones % 2) == 0);
      n++;
    end
    exp_bits[n] = 1'b1;
    n++;
    if (s2) begin
      exp_bits[n] = 1'b1;
      n++;
    end
    for (int b = 0; b < n; b++) begin
      bad = 1'b0;
      a_txd = 1'b0; a_busy = 1'b0; a_done = 1'b0;
      for (int c = 0; c < CPB; c++) begin
        if (!bad && (txd !== exp_bits[b] || busy !== 1'b1 ||
                     (!(b == 0 && c == 0) && frame_done !== 1'b0))) begin
          bad = 1'b1;
          a_txd = txd; a_busy = busy; a_done = frame_done;
        end
        @(negedge clk);
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s bit%0d: got txd=%b busy=%b done=%b, required txd=%b busy=1 done=0 for %0d cycles",
                 tag, b, a_txd, a_busy, a_done, exp_bits[b], CPB);
      end
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_done: got %b, required 1 after %0d cycles", tag, frame_done, n * CPB);
    end
  endtask

  task automatic run_single(input logic [7:0] data, input logic [1:0] len,
                            input logic [1:0] par, input logic s2, input string tag);
    set_cfg(len, par, s2);
    @(negedge clk);
    bus.in_data  = data;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (txd !== 1'b1 || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL %s accept: got txd=%b count=%0d, required txd=1 count=1", tag, txd, fifo_count);
    end
    @(negedge clk);
    checks++;
    if (txd !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s pop: got txd=%b count=%0d busy=%b, required 0/0/1", tag, txd, fifo_count, busy);
    end
    check_frame(data, len, par, s2, tag);
    checks++;
    if (busy !== 1'b0 || txd !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_after: got busy=%b txd=%b, required 0/1", tag, busy, txd);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse_width: got %b, required 0", tag, frame_done);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    set_cfg(2'd3, 2'd0, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 ||
        fifo_count !== 3'd0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got txd=%b busy=%b done=%b count=%0d ready=%b, required 1/0/0/0/1",
               txd, busy, frame_done, fifo_count, bus.in_ready);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_formats();
    run_single(8'hA5, 2'd3, 2'd0, 1'b0, "8N1");
    run_single(8'h53, 2'd2, 2'd1, 1'b1, "7E2");
    run_single(8'hFF, 2'd0, 2'd2, 1'b0, "5O1");
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 6; k++) begin
      run_single(8'($urandom), 2'($urandom_range(3)), 2'($urandom_range(3)),
                 1'($urandom_range(1)), $sformatf("rand%0d", k));
    end
  endtask

  task automatic test_back_to_back();
    int         acc;
    logic [7:0] nxt;
    bit         ok;
    acc = 0;
    nxt = 8'h01;
    set_cfg(2'd3, 2'd0, 1'b0);
    fork
      begin
        bit will;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          bus.in_valid = 1'b1;
          bus.in_data  = nxt;
          will = bus.in_ready;
          @(posedge clk);
          if (will) begin
            acc++;
            nxt++;
          end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (acc != 5 || bus.in_ready !== 1'b0 || fifo_count !== 3'd4) begin
          errors++;
          $display("FAIL b2b_accept: got accepted=%0d ready=%b count=%0d, required 5/0/4",
                   acc, bus.in_ready, fifo_count);
        end
      end
      begin
        wait_fall(20, ok);
        if (ok) begin
          for (int k = 1; k <= 5; k++)
            check_frame(8'(k), 2'd3, 2'd0, 1'b0, $sformatf("b2b%0d", k));
        end
      end
    join
    checks++;
    if (busy !== 1'b0 || txd !== 1'b1 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL b2b_end: got busy=%b txd=%b count=%0d, required 0/1/0", busy, txd, fifo_count);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d0;
    bit         bad;
    d0 = 8'($urandom) & 8'hF7;
    set_cfg(2'd3, 2'd0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d0;
    @(negedge clk);
    bus.in_data  = 8'($urandom);
    @(negedge clk);
    bus.in_data  = 8'($urandom);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (43) @(negedge clk);
    checks++;
    if (txd !== 1'b0 || fifo_count !== 3'd2) begin
      errors++;
      $display("FAIL midframe_bit3: got txd=%b count=%0d, required 0/2", txd, fifo_count);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 ||
        bus.in_ready !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: got txd=%b busy=%b count=%0d ready=%b done=%b, required 1/0/0/1/0",
               txd, busy, fifo_count, bus.in_ready, frame_done);
    end
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || frame_done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midframe_quiet: line not idle after reset, txd=%b done=%b busy=%b", txd, frame_done, busy);
    end
  endtask

  task automatic test_cfg_change();
    logic [7:0] b0, b1;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    set_cfg(2'd3, 2'd0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b0;
    @(negedge clk);
    bus.in_data  = b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    fork
      begin
        check_frame(b0, 2'd3, 2'd0, 1'b0, "cfg_old");
        check_frame(b1, 2'd0, 2'd1, 1'b1, "cfg_new");
      end
      begin
        repeat (30) @(negedge clk);
        set_cfg(2'd0, 2'd1, 1'b1);
      end
    join
    checks++;
    if (busy !== 1'b0 || txd !== 1'b1) begin
      errors++;
      $display("FAIL cfg_end: got busy=%b txd=%b, required 0/1", busy, txd);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_formats();
    test_random_frames();
    test_back_to_back();
    test_reset_mid_frame();
    test_cfg_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
